ch_advert_tx: RTL and testbench
===============================

// Module: ch_advert_tx
// PURPOSE
// - Transmit side of the cluster-head (CH) advertisement exchange. It builds the CH advertisement
//   packet that neighbour nodes' known-CH tables consume as ID/hops/Q-value.
// - On a start pulse it captures the node's own CH information and serialises it as a fixed
//   6-word, 16-bit packet toward the radio/packet buffer, using a valid/ready handshake.
// PARAMETERS
// - WORD_WIDTH   16    data word width; all fields are WORD_WIDTH wide
// - PKT_TYPE     4'hC  message-type nibble placed in the header word
// - STALL_LIMIT  64    consecutive cycles with tx_valid=1 and tx_ready=0 before the packet aborts
// PORTS
// - clk         in   1   system clock; all logic on rising edge
// - nrst        in   1   reset; asynchronous, active-high (asserted = 1 despite the name)
// - start_tx    in   1   one-cycle request to send one advertisement
// - is_CH       in   1   1 = this node is a CH (advertise hops=0); 0 = relay its own route
// - own_ID      in   16  this node's ID
// - own_Hops    in   16  hops from this node to its CH; 0xFFFF = no route
// - own_QValue  in   16  this node's Q-value, fixed point, 0x4000 = 1.00
// - CH_limit    in   16  CH limit carried in the advertisement
// - tx_ready    in   1   downstream accepts tx_data this cycle
// - tx_data     out  16  packet word
// - tx_valid    out  1   tx_data is valid
// - tx_last     out  1   high with the final word (checksum)
// - busy        out  1   packet in progress (any state except IDLE)
// - done        out  1   one-cycle pulse; packet fully accepted
// - err         out  1   one-cycle pulse; request rejected or packet aborted
// BEHAVIOUR
// - Reset: FSM=IDLE; tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, err=0; all latches and
//   the stall counter = 0.
// - States: IDLE -> HDR -> ID -> HOPS -> QV -> LIM -> CSUM -> IDLE.
// - Start in IDLE:
//   - Reject (err=1 next cycle, stay IDLE) when is_CH=0 and own_Hops=0xFFFF.
//   - Otherwise, on the start edge, latch all inputs and the hops field, and go to HDR.
//   - tx_valid=1 on the next cycle, so latency from start to the first word is 1 cycle.
// - Start while busy is ignored, with no err pulse.
// - Hops field: is_CH=1 -> 0x0000; else own_Hops+1, saturating at 0xFFFE (0xFFFE stays 0xFFFE).
// - Word order:
//   - header = {PKT_TYPE, 4'h0, 8'd6}
//   - own_ID
//   - hops field
//   - own_QValue
//   - CH_limit
//   - checksum = XOR of the previous 5 words
// - Checksum is accumulated as each word is emitted; it does not depend on the handshake timing.
// - Handshake:
//   - A word transfers on a clk edge with tx_valid & tx_ready.
//   - tx_data and tx_last hold stable while tx_valid=1 and tx_ready=0.
//   - tx_valid stays 1 from HDR through CSUM. The next word appears in the cycle after a transfer.
//   - Back-to-back transfers give 1 word/cycle, so with tx_ready tied high the packet takes 6 cycles.
// - tx_last=1 only in CSUM.
// - done pulses the cycle after the CSUM transfer, with tx_valid=0, busy=0 and FSM=IDLE.
// - Stall counter:
//   - Clears on every transfer and counts cycles with tx_valid & !tx_ready.
//   - On reaching STALL_LIMIT the packet aborts: next cycle tx_valid=0, err=1, FSM=IDLE.
//     No done pulse.
// - A start_tx in the same cycle as done or err is in IDLE and is accepted.
// - Reset mid-packet returns to the reset state immediately. No done or err is produced.
// TESTING
// - ID=23, Hops=2, is_CH=0, Q=0x3000, limit=3, ready=1 -> C006,0017,0003,3000,0003,F011;
//   tx_last on F011; done 1 cycle later.
// - is_CH=1, ID=12, Q=0x4000, limit=3 -> hops word 0x0000; checksum equals the XOR of the 5 words.
// - is_CH=0, own_Hops=0xFFFF -> err pulse, tx_valid never asserts. own_Hops=0xFFFE -> hops word 0xFFFE.
// - tx_ready low 5 cycles during the QV word -> 0x3000 held stable. Second start_tx mid-packet
//   ignored. Packet completes.
// - tx_ready=0 for STALL_LIMIT cycles on HDR -> err pulse, busy=0, no done. Next start sends normally.
// - nrst=1 asserted during LIM -> outputs return to 0 asynchronously. After release, a new packet
//   is correct.

Source files
------------

// File: rtl/ch_advert_tx.sv
// Cluster-head advertisement transmitter: captures the node's CH info on start_tx and
// streams a 6-word packet (header, ID, hops, Q-value, CH limit, XOR checksum) over valid/ready.
module ch_advert_tx #(
    parameter int         WORD_WIDTH  = 16,
    parameter logic [3:0] PKT_TYPE    = 4'hC,
    parameter int         STALL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start_tx,
    input  logic                  is_CH,
    input  logic [WORD_WIDTH-1:0] own_ID,
    input  logic [WORD_WIDTH-1:0] own_Hops,
    input  logic [WORD_WIDTH-1:0] own_QValue,
    input  logic [WORD_WIDTH-1:0] CH_limit,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]         STALL_MAX = SW'(STALL_LIMIT - 1);
    localparam logic [WORD_WIDTH-1:0] HDR_WORD  = WORD_WIDTH'({PKT_TYPE, 4'h0, 8'd6});
    localparam logic [WORD_WIDTH-1:0] HOPS_SAT  = {{(WORD_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WORD_WIDTH-1:0] NO_ROUTE  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ID, S_HOPS, S_QV, S_LIM, S_CSUM
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   id_q, hops_q, qv_q, lim_q, csum_q;
    logic [WORD_WIDTH-1:0]   tx_data_q, word_d, hops_d;
    logic                    tx_valid_q, tx_last_q, done_q, err_q;
    logic [SW-1:0]           stall_q;
    logic                    reject;

    assign reject = !is_CH && (own_Hops == NO_ROUTE);

    always_comb begin
        hops_d = '0;
        if (!is_CH) begin
            hops_d = (own_Hops >= HOPS_SAT) ? HOPS_SAT : own_Hops + WORD_WIDTH'(1);
        end
    end

    // Word that follows the one currently presented, and the state that presents it.
    always_comb begin
        word_d  = '0;
        state_d = S_IDLE;
        case (state_q)
            S_HDR:  begin word_d = id_q;   state_d = S_ID;   end
            S_ID:   begin word_d = hops_q; state_d = S_HOPS; end
            S_HOPS: begin word_d = qv_q;   state_d = S_QV;   end
            S_QV:   begin word_d = lim_q;  state_d = S_LIM;  end
            S_LIM:  begin word_d = csum_q; state_d = S_CSUM; end
            default: begin word_d = '0;    state_d = S_IDLE; end
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            hops_q     <= '0;
            qv_q       <= '0;
            lim_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                stall_q <= '0;
                if (start_tx) begin
                    if (reject) begin
                        err_q <= 1'b1;
                    end else begin
                        id_q       <= own_ID;
                        hops_q     <= hops_d;
                        qv_q       <= own_QValue;
                        lim_q      <= CH_limit;
                        csum_q     <= HDR_WORD;
                        tx_data_q  <= HDR_WORD;
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        state_q    <= S_HDR;
                    end
                end
            end else if (tx_ready) begin
                stall_q <= '0;
                if (state_q == S_CSUM) begin
                    state_q    <= S_IDLE;
                    tx_data_q  <= '0;
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    done_q     <= 1'b1;
                end else begin
                    // The checksum word itself is not folded back into the running XOR.
                    if (state_q != S_LIM) begin
                        csum_q <= csum_q ^ word_d;
                    end
                    tx_data_q <= word_d;
                    tx_last_q <= (state_q == S_LIM);
                    state_q   <= state_d;
                end
            end else if (stall_q == STALL_MAX) begin
                state_q    <= S_IDLE;
                tx_data_q  <= '0;
                tx_valid_q <= 1'b0;
                tx_last_q  <= 1'b0;
                err_q      <= 1'b1;
                stall_q    <= '0;
            end else begin
                stall_q <= stall_q + SW'(1);
            end
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ch_advert_tx.sv
// Bench for ch_advert_tx: directed and randomized packets compared against a packet model
// built from the field rules (header, saturating hops, XOR checksum) with ready stalls.
module tb_ch_advert_tx;

    localparam int STALL_LIMIT = 64;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start_tx;
    logic        is_CH;
    logic [15:0] own_ID, own_Hops, own_QValue, CH_limit;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_last, busy, done, err;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_w [6];

    ch_advert_tx #(.WORD_WIDTH(16), .PKT_TYPE(4'hC), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .nrst(nrst), .start_tx(start_tx), .is_CH(is_CH),
        .own_ID(own_ID), .own_Hops(own_Hops), .own_QValue(own_QValue), .CH_limit(CH_limit),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packet straight from the field rules.
    task automatic build_pkt(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q,
                             input logic [15:0] lim, input logic isch);
        int hops;
        if (isch) hops = 0;
        else if (int'(h) + 1 > 'hFFFE) hops = 'hFFFE;
        else hops = int'(h) + 1;
        exp_w[0] = 16'hC006;
        exp_w[1] = id;
        exp_w[2] = 16'(hops);
        exp_w[3] = q;
        exp_w[4] = lim;
        exp_w[5] = exp_w[0] ^ exp_w[1] ^ exp_w[2] ^ exp_w[3] ^ exp_w[4];
    endtask

    // mode 0: ready always high; 1: random ready; 2: 5-cycle stall on QV plus a mid-packet start.
    task automatic run_pkt(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q,
                           input logic [15:0] lim, input logic isch, input int mode);
        int k, cyc, stall_run;
        logic have_prev, rdy;
        logic [15:0] prev_data;
        build_pkt(id, h, q, lim, isch);
        own_ID = id; own_Hops = h; own_QValue = q; CH_limit = lim; is_CH = isch;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        k = 0; cyc = 0; stall_run = 0; have_prev = 1'b0; prev_data = '0;
        while (k < 6 && cyc < 300) begin
            check("valid_in_pkt", tx_valid, 1);
            check("busy_in_pkt", busy, 1);
            check("err_in_pkt", err, 0);
            check("done_in_pkt", done, 0);
            if (have_prev) check("hold_data", tx_data, prev_data);
            case (mode)
                0: rdy = 1'b1;
                2: rdy = !(k == 3 && stall_run < 5);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && k == 1) begin
                start_tx = 1'b1;
                is_CH = 1'b0;
                own_Hops = 16'hFFFF;
            end else begin
                start_tx = 1'b0;
            end
            if (rdy) begin
                check($sformatf("word%0d", k), tx_data, exp_w[k]);
                check($sformatf("last%0d", k), tx_last, (k == 5));
                k++;
                have_prev = 1'b0;
            end else begin
                if (k == 3) stall_run++;
                prev_data = tx_data;
                have_prev = 1'b1;
            end
            tx_ready = rdy;
            tick();
            cyc++;
        end
        start_tx = 1'b0;
        check("pkt_words_done", k, 6);
        if (mode == 0) check("pkt_cycles", cyc, 6);
        if (mode == 2) check("qv_stall_cycles", stall_run, 5);
        check("done_pulse", done, 1);
        check("valid_after", tx_valid, 0);
        check("busy_after", busy, 0);
        check("err_after", err, 0);
    endtask

    task automatic run_reject();
        is_CH = 1'b0;
        own_Hops = 16'hFFFF;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        check("rej_err", err, 1);
        check("rej_valid", tx_valid, 0);
        check("rej_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rej_valid_later", tx_valid, 0);
            check("rej_err_single", err, 0);
        end
    endtask

    initial begin
        logic [15:0] rh;
        logic        risch;
        nrst = 1'b1; start_tx = 1'b0; is_CH = 1'b0; tx_ready = 1'b1;
        own_ID = '0; own_Hops = '0; own_QValue = '0; CH_limit = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", tx_data, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_last", tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        nrst = 1'b0;
        tick();

        run_pkt(16'd23, 16'd2, 16'h3000, 16'd3, 1'b0, 0);
        check("example_csum", exp_w[5], 16'hF011);
        tick();
        run_pkt(16'd12, 16'h1234, 16'h4000, 16'd3, 1'b1, 0);
        tick();
        run_reject();
        run_pkt(16'h0042, 16'hFFFE, 16'h2000, 16'd5, 1'b0, 0);
        check("sat_hops_model", exp_w[2], 16'hFFFE);
        tick();
        run_pkt(16'd23, 16'd2, 16'h3000, 16'd3, 1'b0, 2);
        tick();

        // Stall the header for the full limit: abort with err, no done.
        own_ID = 16'h0101; own_Hops = 16'd4; own_QValue = 16'h1000; CH_limit = 16'd2; is_CH = 1'b0;
        tx_ready = 1'b0;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        for (int i = 0; i < STALL_LIMIT; i++) begin
            check("stall_valid", tx_valid, 1);
            check("stall_hdr_hold", tx_data, 16'hC006);
            check("stall_err_early", err, 0);
            tick();
        end
        check("abort_err", err, 1);
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tx_ready = 1'b1;
        tick();
        check("abort_err_pulse", err, 0);
        check("abort_no_done", done, 0);
        run_pkt(16'h0101, 16'd4, 16'h1000, 16'd2, 1'b0, 0);
        tick();

        // Asynchronous reset while the CH-limit word is presented.
        own_ID = 16'h0777; own_Hops = 16'd9; own_QValue = 16'h3FFF; CH_limit = 16'd7; is_CH = 1'b0;
        tx_ready = 1'b1;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (4) tick();
        check("pre_rst_lim", tx_data, 16'd7);
        #2 nrst = 1'b1;
        #1;
        check("arst_data", tx_data, 0);
        check("arst_valid", tx_valid, 0);
        check("arst_last", tx_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        tick();
        check("arst_no_done", done, 0);
        nrst = 1'b0;
        tick();
        run_pkt(16'h0555, 16'd1, 16'h0800, 16'd4, 1'b0, 0);

        // Randomized packets; each starts in the cycle the previous one reports done.
        for (int n = 0; n < 24; n++) begin
            risch = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rh = 16'hFFFF;
                1: rh = 16'hFFFE;
                default: rh = 16'($urandom);
            endcase
            if (!risch && rh == 16'hFFFF) run_reject();
            else run_pkt(16'($urandom), rh, 16'($urandom), 16'($urandom), risch, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
